branch_predictor: RTL

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

---
 rtl/branch_predictor.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/branch_predictor.sv
// Branch predictor: a direct-mapped BTB with 2-bit saturating direction counters.
// Fetch lookup is combinational. Execute-stage resolution updates the table,
// flags mispredicts, supplies the redirect PC and drives a one-cycle recovery flush.
module branch_predictor #(
    parameter int unsigned PC_W  = 9,
    parameter int unsigned IDX_W = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    // Fetch-side lookup
    input  logic [PC_W-1:0] Fetch_PC,
    output logic            PredTaken,
    output logic [31:0]     PredTarget,
    // Execute-side resolution
    input  logic            Ex_Valid,
    input  logic            Ex_IsBr,
    input  logic [PC_W-1:0] Ex_PC,
    input  logic            Ex_Taken,
    input  logic [31:0]     Ex_Target,
    input  logic            Ex_PredTaken,
    input  logic [31:0]     Ex_PredTarget,
    input  logic            Stall,
    // Recovery
    output logic            Mispredict,
    output logic [31:0]     Redirect_PC,
    output logic            Flush,
    // Statistics
    output logic [15:0]     BrCount,
    output logic [15:0]     MispCount
);

    localparam int unsigned Entries = 1 << IDX_W;
    localparam int unsigned TagW    = PC_W - IDX_W - 2;

    typedef enum logic {
        StIdle,
        StRecover
    } state_e;

    // Table storage
    logic [Entries-1:0] valid_q;
    logic [TagW-1:0]    tag_q [Entries];
    logic [PC_W-1:0]    tgt_q [Entries];
    logic [1:0]         ctr_q [Entries];

    // Single write port, computed from the execute-stage resolution
    logic               wr_en;
    logic [IDX_W-1:0]   wr_idx;
    logic [TagW-1:0]    wr_tag;
    logic [PC_W-1:0]    wr_tgt;
    logic [1:0]         wr_ctr;

    state_e             state_q, state_d;
    logic [15:0]        br_cnt_q, br_cnt_d;
    logic [15:0]        misp_cnt_q, misp_cnt_d;

    // Fetch lookup signals
    logic [IDX_W-1:0]   fetch_idx;
    logic [TagW-1:0]    fetch_tag;
    logic               fetch_hit;
    logic [PC_W-1:0]    fetch_pc_inc;

    // Execute resolution signals
    logic [IDX_W-1:0]   ex_idx;
    logic [TagW-1:0]    ex_tag;
    logic               ex_hit;
    logic               ex_taken_eff;
    logic               ex_active;
    logic               upd_en;
    logic               misp;
    logic [PC_W-1:0]    ex_pc_inc;
    logic [PC_W-1:0]    ex_tgt_lo;
    logic [PC_W-1:0]    ex_ptgt_lo;

    // Upper target bits are architecturally ignored (targets live in PC_W bits)
    logic               unused_tgt_bits;
    assign unused_tgt_bits = ^(Ex_Target >> PC_W) ^ ^(Ex_PredTarget >> PC_W);

    // Fetch-stage lookup reads registered table contents, so a same-cycle write
    // to the same index is seen only from the following cycle.
    always_comb begin
        fetch_idx    = Fetch_PC[IDX_W+1:2];
        fetch_tag    = Fetch_PC[PC_W-1:IDX_W+2];
        fetch_hit    = valid_q[fetch_idx] && (tag_q[fetch_idx] == fetch_tag);
        fetch_pc_inc = Fetch_PC + PC_W'(4);
        PredTaken    = fetch_hit && ctr_q[fetch_idx][1];
        PredTarget   = PredTaken ? 32'(tgt_q[fetch_idx]) : 32'(fetch_pc_inc);
    end

    // Execute-stage resolution: qualify, detect mispredict, form redirect.
    always_comb begin
        ex_idx       = Ex_PC[IDX_W+1:2];
        ex_tag       = Ex_PC[PC_W-1:IDX_W+2];
        ex_hit       = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
        ex_tgt_lo    = Ex_Target[PC_W-1:0];
        ex_ptgt_lo   = Ex_PredTarget[PC_W-1:0];
        ex_pc_inc    = Ex_PC + PC_W'(4);
        // A non-branch can never actually be taken, whatever the unit reports.
        ex_taken_eff = Ex_IsBr && Ex_Taken;
        // rst_n gating keeps the combinational outputs quiet while in reset.
        ex_active    = rst_n && Ex_Valid && !Stall && (state_q == StIdle);
        upd_en       = ex_active && Ex_IsBr;
        misp         = ex_active &&
                       ((ex_taken_eff != Ex_PredTaken) ||
                        (ex_taken_eff && (ex_tgt_lo != ex_ptgt_lo)));
        Mispredict   = misp;
        if (!misp) begin
            Redirect_PC = '0;
        end else if (ex_taken_eff) begin
            Redirect_PC = 32'(ex_tgt_lo);
        end else begin
            Redirect_PC = 32'(ex_pc_inc);
        end
    end

    // Table write-port: train on a hit, allocate on a taken miss, else leave alone.
    always_comb begin
        wr_en  = 1'b0;
        wr_idx = ex_idx;
        wr_tag = ex_tag;
        wr_tgt = tgt_q[ex_idx];
        wr_ctr = ctr_q[ex_idx];
        if (upd_en) begin
            if (ex_hit) begin
                wr_en = 1'b1;
                if (Ex_Taken) begin
                    wr_tgt = ex_tgt_lo;
                    if (ctr_q[ex_idx] != 2'd3) begin
                        wr_ctr = ctr_q[ex_idx] + 2'd1;
                    end
                end else if (ctr_q[ex_idx] != 2'd0) begin
                    wr_ctr = ctr_q[ex_idx] - 2'd1;
                end
            end else if (Ex_Taken) begin
                wr_en  = 1'b1;
                wr_tgt = ex_tgt_lo;
                wr_ctr = 2'd2;
            end
        end
    end

    // Table state: reset to invalid, weakly-not-taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            for (int i = 0; i < int'(Entries); i++) begin
                tag_q[i] <= '0;
                tgt_q[i] <= '0;
                ctr_q[i] <= 2'd1;
            end
        end else if (wr_en) begin
            valid_q[wr_idx] <= 1'b1;
            tag_q[wr_idx]   <= wr_tag;
            tgt_q[wr_idx]   <= wr_tgt;
            ctr_q[wr_idx]   <= wr_ctr;
        end
    end

    // Recovery FSM next state: one RECOVER cycle after a mispredict, held by Stall.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (misp) begin
                    state_d = StRecover;
                end
            end
            StRecover: begin
                if (!Stall) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        Flush = misp || (state_q == StRecover);
    end

    // Recovery FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Statistics next state: saturating counts of updates and mispredicts.
    always_comb begin
        br_cnt_d   = br_cnt_q;
        misp_cnt_d = misp_cnt_q;
        if (upd_en && (br_cnt_q != 16'hFFFF)) begin
            br_cnt_d = br_cnt_q + 16'd1;
        end
        if (misp && (misp_cnt_q != 16'hFFFF)) begin
            misp_cnt_d = misp_cnt_q + 16'd1;
        end
    end

    // Statistics registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_cnt_q   <= '0;
            misp_cnt_q <= '0;
        end else begin
            br_cnt_q   <= br_cnt_d;
            misp_cnt_q <= misp_cnt_d;
        end
    end

    assign BrCount   = br_cnt_q;
    assign MispCount = misp_cnt_q;

endmodule
